// File: rtl/debounce_pkg.sv
// Shared types and elaboration helpers for the input debouncer.
package debounce_pkg;

  // Per-bit debounce FSM states.
  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_e;

  // Smallest counter width w such that 2^w >= cycles.
  function automatic int min_cnt_w(input int cycles);
    int w;
    w = 1;
    while ((longint'(1) << w) < longint'(cycles)) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Pin level that means "not pressed".
  function automatic logic inactive_level(input int active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchronizer, stability counter and press/release strobe generator.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic clean_o,
  output logic press_o,
  output logic release_o,
  output logic strobe_d_o
);

  localparam logic             INACTIVE = inactive_level(ACTIVE_LOW);
  localparam logic             PRESSED  = ~INACTIVE;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  db_state_e        state_q, state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             mismatch;
  logic             accept;

  assign mismatch = (sync2_q != clean_q);
  // Terminal count reached while the new level is still present.
  assign accept   = (state_q == DB_COUNT) && mismatch && (cnt_q == TERMINAL);

  // State register: synchronizer, FSM, counter, clean level and strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q   <= INACTIVE;
      sync2_q   <= INACTIVE;
      clean_q   <= INACTIVE;
      cnt_q     <= '0;
      state_q   <= DB_IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      clean_q   <= clean_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic: the counter holds the number of consecutive mismatched
  // samples seen, so the first mismatch loads 1 and acceptance happens on
  // the DEBOUNCE_CYCLES-th mismatched sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    case (state_q)
      DB_IDLE: begin
        cnt_d = '0;
        if (mismatch) begin
          state_d = DB_COUNT;
          cnt_d   = CNT_W'(1);
        end
      end
      DB_COUNT: begin
        if (!mismatch) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TERMINAL) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
          clean_d = sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: direction of the accepted transition selects the strobe.
  always_comb begin
    press_d   = accept && (sync2_q == PRESSED);
    release_d = accept && (sync2_q != PRESSED);
  end

  assign clean_o    = clean_q;
  assign press_o    = press_q;
  assign release_o  = release_q;
  assign strobe_d_o = press_d | release_d;

endmodule

// File: rtl/input_debouncer.sv
// Debounces WIDTH independent raw inputs and flags level changes.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = min_cnt_w(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic             any_change
);

  logic [WIDTH-1:0] strobe_d_w;
  logic             any_change_q;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (ACTIVE_LOW),
        .CNT_W          (CNT_W)
      ) u_bit (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw_i     (raw_in[gi]),
        .clean_o   (clean_out[gi]),
        .press_o   (press_pulse[gi]),
        .release_o (release_pulse[gi]),
        .strobe_d_o(strobe_d_w[gi])
      );
    end
  endgenerate

  // any_change is registered from the strobes' next values so it lines up
  // with press_pulse/release_pulse in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= |strobe_d_w;
    end
  end

  assign any_change = any_change_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer (8-cycle debounce, active-low).
module tb_input_debouncer;

  localparam int WIDTH = 4;
  localparam int DC    = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clean_out;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;
  logic             any_change;

  int checks   = 0;
  int failures = 0;

  input_debouncer #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW     (1),
    .CNT_W          (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .raw_in       (raw_in),
    .clean_out    (clean_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .any_change   (any_change)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] c, input logic [3:0] p,
                           input logic [3:0] r, input logic a);
    check({tag, ".clean"}, 32'(clean_out), 32'(c));
    check({tag, ".press"}, 32'(press_pulse), 32'(p));
    check({tag, ".release"}, 32'(release_pulse), 32'(r));
    check({tag, ".any"}, 32'(any_change), 32'(a));
    $display("step %s raw=%b clean=%b press=%b release=%b any=%b",
             tag, raw_in, clean_out, press_pulse, release_pulse, any_change);
  endtask

  // Step n cycles, checking each cycle that clean holds and nothing strobes.
  task automatic hold_check(input string tag, input int n, input logic [3:0] c);
    for (int i = 0; i < n; i++) begin
      step(1);
      check_all(tag, c, 4'b0000, 4'b0000, 1'b0);
    end
  endtask

  initial begin
    // 1. Reset with raw low, then initial press acceptance.
    reset_n = 1'b0;
    raw_in  = 4'b0000;
    step(3);
    check_all("reset", 4'b1111, 4'b0000, 4'b0000, 1'b0);
    reset_n = 1'b1;
    hold_check("post_reset", 9, 4'b1111);
    step(1);
    check_all("init_press", 4'b0000, 4'b1111, 4'b0000, 1'b1);
    step(1);
    check_all("init_press_end", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Release all bits to reach the idle (all-high) level.
    raw_in = 4'b1111;
    hold_check("rel_all_wait", 9, 4'b0000);
    step(1);
    check_all("rel_all", 4'b1111, 4'b0000, 4'b1111, 1'b1);
    step(1);
    check_all("rel_all_end", 4'b1111, 4'b0000, 4'b0000, 1'b0);

    // 2. Clean press on bit 1.
    raw_in = 4'b1101;
    hold_check("press1_wait", 9, 4'b1111);
    step(1);
    check_all("press1", 4'b1101, 4'b0010, 4'b0000, 1'b1);
    step(1);
    check_all("press1_end", 4'b1101, 4'b0000, 4'b0000, 1'b0);

    // 3. Bounce on bit 2: low 5, high 2, low 3, then high.
    raw_in = 4'b1001;
    hold_check("bounce_a", 5, 4'b1101);
    raw_in = 4'b1101;
    hold_check("bounce_b", 2, 4'b1101);
    raw_in = 4'b1001;
    hold_check("bounce_c", 3, 4'b1101);
    raw_in = 4'b1101;
    hold_check("bounce_d", 12, 4'b1101);

    // 4. Release bit 1.
    raw_in = 4'b1111;
    hold_check("rel1_wait", 9, 4'b1101);
    step(1);
    check_all("rel1", 4'b1111, 4'b0000, 4'b0010, 1'b1);
    step(1);
    check_all("rel1_end", 4'b1111, 4'b0000, 4'b0000, 1'b0);

    // 5. Simultaneous press on bits 0 and 3.
    raw_in = 4'b0110;
    hold_check("sim_wait", 9, 4'b1111);
    step(1);
    check_all("sim_press", 4'b0110, 4'b1001, 4'b0000, 1'b1);
    step(1);
    check_all("sim_end", 4'b0110, 4'b0000, 4'b0000, 1'b0);
    raw_in = 4'b1111;
    hold_check("sim_rel_wait", 9, 4'b0110);
    step(1);
    check_all("sim_rel", 4'b1111, 4'b0000, 4'b1001, 1'b1);
    step(1);
    check_all("sim_rel_end", 4'b1111, 4'b0000, 4'b0000, 1'b0);

    // 6. Reset pulse while bit 0 is mid-count (count 5).
    raw_in = 4'b1110;
    hold_check("midcnt", 7, 4'b1111);
    reset_n = 1'b0;
    step(1);
    check_all("midcnt_reset", 4'b1111, 4'b0000, 4'b0000, 1'b0);
    reset_n = 1'b1;
    hold_check("midcnt_after", 9, 4'b1111);
    step(1);
    check_all("midcnt_press", 4'b1110, 4'b0001, 4'b0000, 1'b1);
    step(1);
    check_all("midcnt_end", 4'b1110, 4'b0000, 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
